// File: rtl/iter_alu_exec.sv
// Multi-cycle execute unit: single-cycle logic/arith/compare, iterative one-bit-per-cycle shifts,
// valid/ready handshake on both request and result sides.
module iter_alu_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             is_illegal;
  logic [WIDTH-1:0] first_shift;
  logic [WIDTH-1:0] next_shift;

  // One bit-position step of the iterative shifter.
  function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op, input logic [WIDTH-1:0] v);
    case (op)
      OP_SLL:  return {v[WIDTH-2:0], 1'b0};
      OP_SRA:  return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return {1'b0, v[WIDTH-1:1]};
    endcase
  endfunction

  // Single-cycle ops, evaluated on the request as it is accepted.
  always_comb begin
    alu_res = '0;
    case (alu_control)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a + ~src_b + WIDTH'(1);
      OP_SLT:  alu_res = WIDTH'($signed(src_a) < $signed(src_b));
      OP_SLTU: alu_res = WIDTH'(src_a < src_b);
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_AND:  alu_res = src_a & src_b;
      default: alu_res = '0;
    endcase
  end

  assign shamt       = src_b[SHW-1:0];
  assign is_shift    = (alu_control == OP_SLL) || (alu_control == OP_SRA) || (alu_control == OP_SRL);
  assign is_illegal  = (alu_control > OP_AND);
  assign first_shift = shift_one(alu_control, src_a);
  assign next_shift  = shift_one(op_q, res_q);

  // The first shift step happens on the accept edge so latency equals shamt.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d  = alu_control;
          ill_d = is_illegal;
          if (is_shift && (shamt != '0)) begin
            res_d  = first_shift;
            cnt_d  = shamt - SHW'(1);
            zero_d = (first_shift == '0);
            state_d = (shamt == SHW'(1)) ? S_DONE : S_SHIFT;
          end else begin
            res_d   = is_shift ? src_a : alu_res;
            cnt_d   = '0;
            zero_d  = is_shift ? (src_a == '0) : (alu_res == '0);
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        res_d = next_shift;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          zero_d  = (next_shift == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      ill_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      ill_q       <= ill_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign result     = res_q;
  assign zero       = zero_q;
  assign illegal_op = ill_q;

endmodule

// File: doc/iter_alu_exec.md
Name: iter_alu_exec

Overview:
- Multi-cycle execute unit. It consumes the 4-bit ALUControl code produced by the controller's ALU decode stage, together with two operands, and returns a result plus a zero flag.
- Logic, arithmetic and compare ops complete in one cycle. Shifts are iterative, one bit position per cycle, to save area.
- Uses a valid/ready handshake on both input and output so it can sit between decode and writeback in a multi-cycle core variant.

Parameters:
- WIDTH, 32, operand/result width. Must be a power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- alu_control  in  4  operation code: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 sra, 0111 srl, 1000 or, 1001 and
- src_a  in  WIDTH  operand A
- src_b  in  WIDTH  operand B; for shifts only src_b[SHW-1:0] is used
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- illegal_op  out  1  code was 1010..1111; qualified by out_valid

Behaviour:
- Reset: sampled only on a clk edge with rst_n=0.
  - State goes to IDLE.
  - result=0, zero=0, illegal_op=0, out_valid=0, in_ready=0 during the reset cycle.
  - in_ready=1 in the first cycle after rst_n rises.
  - Reset mid-shift or while holding a result discards the operation; no output is produced.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept occurs when in_valid & in_ready. At accept, alu_control, src_a and the shift amount are registered; later input changes have no effect.
- IDLE, non-shift op accepted:
  - Result computed from the registered inputs, state goes to DONE.
  - out_valid rises the cycle after accept (latency 1).
- IDLE, shift op (0010/0110/0111) accepted:
  - Working register = src_a, counter = src_b[SHW-1:0].
  - Counter 0: go directly to DONE with result=src_a (latency 1).
  - Otherwise go to SHIFT.
- SHIFT: each cycle the working register shifts by one bit and the counter decrements.
  - sll: shift left, fill 0.
  - srl: shift right, fill 0.
  - sra: shift right, fill with the MSB.
  - When the counter reaches 1, the final shift is applied and the state goes to DONE.
  - Total latency from accept to out_valid = shamt cycles (minimum 1). Shamt WIDTH-1 gives WIDTH-1 cycles.
- DONE:
  - result, zero and illegal_op are held stable until out_valid & out_ready.
  - Then go to IDLE; in_ready=1 the following cycle. There is no same-cycle result-out/request-in overlap.
  - out_ready held high before DONE has no effect.
- Arithmetic: all ops are modulo 2^WIDTH; carry and overflow are discarded.
  - slt: signed compare, result = {WIDTH-1 zeros, a<b}.
  - sltu: unsigned compare, same result format.
  - sub: a + ~b + 1.
- Illegal code: result=0, zero=1, illegal_op=1, latency 1.
- zero is computed from the final result value.
- in_valid may drop without acceptance; no request is latched unless in_ready=1 in that cycle.

Test Plan:
- Reset then add: src_a=0x00000005, src_b=0xFFFFFFFB, code 0000 → out_valid one cycle after accept, result=0x00000000, zero=1, illegal_op=0.
- Sub and compares:
  - sub 3−5 → 0xFFFFFFFE.
  - slt a=0xFFFFFFFF, b=1 → 1.
  - sltu with the same operands → 0.
- Shifts with latency:
  - sll 0x00000001 by 31 → 0x80000000, out_valid exactly 31 cycles after accept.
  - sra 0x80000000 by 4 → 0xF8000000 after 4 cycles.
  - srl same operand and amount → 0x08000000.
  - shamt 0 → src_a after 1 cycle.
  - src_b=0x00000021 uses shamt 1.
- Backpressure: out_ready=0 for 5 cycles in DONE → result/out_valid stable and in_ready=0 throughout; when out_ready=1 the handshake completes and in_ready=1 the next cycle.
- Illegal code 1100 → result=0, zero=1, illegal_op=1.
- Reset mid-operation: rst_n=0 during a SHIFT of 20 → next cycles out_valid=0, result=0, state IDLE; a new xor 0xF0F0F0F0 ^ 0xFFFF0000 → 0x0F0FF0F0.
